// File: rtl/bsg_fifo_1r1w_small_cnt_pkg.sv
// Shared helpers for the small counted FIFO and its wrap-around pointers.
package bsg_fifo_1r1w_small_cnt_pkg;

  // Next pointer value, clearing to zero after the last slot (no power-of-two assumption).
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned slots);
    return (ptr == slots - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/bsg_circ_ptr_wrap.sv
// Circular pointer that steps by one on add_i and wraps to zero after slots_p-1.
module bsg_circ_ptr_wrap
  import bsg_fifo_1r1w_small_cnt_pkg::*;
#(
  parameter int unsigned slots_p = 4,
  parameter int unsigned width_p = $clog2(slots_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               add_i,
  output logic [width_p-1:0] ptr_o
);

  logic [width_p-1:0] r_ptr;
  logic [width_p-1:0] w_ptr_next;

  always_comb begin
    w_ptr_next = r_ptr;
    if (add_i) begin
      w_ptr_next = width_p'(wrap_inc(32'(r_ptr), slots_p));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/bsg_fifo_1r1w_small_cnt.sv
// Small ready/valid-in, valid/yumi-out FIFO with occupancy count and almost-full flag.
module bsg_fifo_1r1w_small_cnt
  import bsg_fifo_1r1w_small_cnt_pkg::*;
#(
  parameter int unsigned width_p          = 16,
  parameter int unsigned els_p            = 4,
  parameter int unsigned almost_full_lo_p = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o,
  output logic                       almost_full_o
);

  localparam int unsigned lg_els_lp = $clog2(els_p);
  localparam int unsigned lg_cnt_lp = $clog2(els_p + 1);

  logic [width_p-1:0]   r_mem [els_p];
  logic [lg_cnt_lp-1:0] r_count;
  logic [lg_cnt_lp-1:0] w_count_next;
  logic [lg_els_lp-1:0] w_wptr;
  logic [lg_els_lp-1:0] w_rptr;
  logic                 w_enq;
  logic                 w_deq;

  // Flags decode only registered count, so nothing here sees v_i or yumi_i.
  assign ready_o       = (r_count != lg_cnt_lp'(els_p));
  assign v_o           = (r_count != '0);
  assign almost_full_o = (r_count >= lg_cnt_lp'(els_p - almost_full_lo_p));
  assign count_o       = r_count;
  assign data_o        = r_mem[w_rptr];

  assign w_enq = v_i & ready_o;
  assign w_deq = yumi_i & v_o;

  always_comb begin
    w_count_next = r_count;
    if (w_enq && !w_deq) begin
      w_count_next = r_count + lg_cnt_lp'(1);
    end else if (!w_enq && w_deq) begin
      w_count_next = r_count - lg_cnt_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // Storage has no reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk_i) begin
    if (w_enq && reset_n_i) begin
      r_mem[w_wptr] <= data_i;
    end
  end

  bsg_circ_ptr_wrap #(
    .slots_p (els_p),
    .width_p (lg_els_lp)
  ) u_wptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .add_i     (w_enq),
    .ptr_o     (w_wptr)
  );

  bsg_circ_ptr_wrap #(
    .slots_p (els_p),
    .width_p (lg_els_lp)
  ) u_rptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .add_i     (w_deq),
    .ptr_o     (w_rptr)
  );

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o is low");

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_cnt.sv
// Directed and random checks of the small FIFO at depth 4 and depth 3 against queue models.
module tb_bsg_fifo_1r1w_small_cnt;

  logic        clk;
  logic        rst4_n, v4, y4, rdy4, vo4, af4;
  logic [15:0] d4, do4;
  logic [2:0]  cnt4;
  logic        rst3_n, v3, y3, rdy3, vo3, af3;
  logic [15:0] d3, do3;
  logic [1:0]  cnt3;

  logic [15:0] q4[$];
  logic [15:0] q3[$];
  int          n_pass;
  int          n_total;
  string       phase;

  bsg_fifo_1r1w_small_cnt #(
    .width_p          (16),
    .els_p            (4),
    .almost_full_lo_p (1)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (rst4_n),
    .v_i           (v4),
    .data_i        (d4),
    .ready_o       (rdy4),
    .v_o           (vo4),
    .data_o        (do4),
    .yumi_i        (y4),
    .count_o       (cnt4),
    .almost_full_o (af4)
  );

  bsg_fifo_1r1w_small_cnt #(
    .width_p          (16),
    .els_p            (3),
    .almost_full_lo_p (1)
  ) dut3 (
    .clk_i         (clk),
    .reset_n_i     (rst3_n),
    .v_i           (v3),
    .data_i        (d3),
    .ready_o       (rdy3),
    .v_o           (vo3),
    .data_o        (do3),
    .yumi_i        (y3),
    .count_o       (cnt3),
    .almost_full_o (af3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
  endtask

  // One clock: model both FIFOs from the inputs presented before the edge, then compare.
  task automatic tick();
    bit e4, q4d, e3, q3d;
    e4  = rst4_n && v4 && (q4.size() < 4);
    q4d = rst4_n && y4 && (q4.size() > 0);
    e3  = rst3_n && v3 && (q3.size() < 3);
    q3d = rst3_n && y3 && (q3.size() > 0);
    @(posedge clk);
    #1;
    if (!rst4_n) q4.delete();
    else begin
      if (q4d) void'(q4.pop_front());
      if (e4) q4.push_back(d4);
    end
    if (!rst3_n) q3.delete();
    else begin
      if (q3d) void'(q3.pop_front());
      if (e3) q3.push_back(d3);
    end
    chk("count4", 32'(cnt4), 32'(q4.size()));
    chk("v4", 32'(vo4), 32'(q4.size() != 0));
    chk("ready4", 32'(rdy4), 32'(q4.size() != 4));
    chk("afull4", 32'(af4), 32'(q4.size() >= 3));
    if (q4.size() > 0) chk("data4", 32'(do4), 32'(q4[0]));
    chk("count3", 32'(cnt3), 32'(q3.size()));
    chk("v3", 32'(vo3), 32'(q3.size() != 0));
    chk("ready3", 32'(rdy3), 32'(q3.size() != 3));
    chk("afull3", 32'(af3), 32'(q3.size() >= 2));
    if (q3.size() > 0) chk("data3", 32'(do3), 32'(q3[0]));
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst4_n = 1'b0; v4 = 1'b0; y4 = 1'b0; d4 = '0;
    rst3_n = 1'b0; v3 = 1'b0; y3 = 1'b0; d3 = '0;

    phase = "reset";
    tick();
    tick();
    rst4_n = 1'b1;
    rst3_n = 1'b1;
    tick();
    chk("cnt4_idle", 32'(cnt4), 32'd0);
    chk("rdy4_idle", 32'(rdy4), 32'd1);

    phase = "fill";
    for (int i = 1; i <= 4; i++) begin
      v4 = 1'b1;
      d4 = 16'hA000 + 16'(i);
      tick();
      chk("fill_cnt", 32'(cnt4), 32'(i));
    end
    v4 = 1'b1;
    d4 = 16'hBEEF;
    tick();
    chk("drop_head", 32'(do4), 32'hA001);

    phase = "drain";
    v4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", 32'(do4), 32'hA000 + 32'(i));
      y4 = 1'b1;
      tick();
    end
    y4 = 1'b0;
    chk("drain_empty", 32'(vo4), 32'd0);

    phase = "simul";
    v4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d4 = 16'hC000 + 16'(i);
      tick();
    end
    for (int i = 2; i < 12; i++) begin
      d4 = 16'hC000 + 16'(i);
      y4 = 1'b1;
      tick();
      chk("simul_cnt", 32'(cnt4), 32'd2);
    end

    phase = "fullboth";
    y4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d4 = 16'hD000 + 16'(i);
      tick();
    end
    d4 = 16'hDEAD;
    y4 = 1'b1;
    tick();
    chk("fullboth_cnt", 32'(cnt4), 32'd3);
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    y4 = 1'b0;

    phase = "midreset";
    v4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d4 = 16'hE000 + 16'(i);
      tick();
    end
    y4 = 1'b1;
    rst4_n = 1'b0;
    tick();
    chk("rst_cnt", 32'(cnt4), 32'd0);
    chk("rst_v", 32'(vo4), 32'd0);
    rst4_n = 1'b1;
    y4 = 1'b0;
    d4 = 16'h1234;
    tick();
    chk("rst_head", 32'(do4), 32'h1234);
    v4 = 1'b0;
    y4 = 1'b1;
    tick();
    y4 = 1'b0;

    phase = "depth3";
    for (int i = 0; i < 40; i++) begin
      v3 = 1'($urandom_range(0, 1));
      d3 = 16'($urandom);
      y3 = (q3.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      chk("cnt3_max", 32'(cnt3 <= 2'd3), 32'd1);
      chk("rptr3_max", 32'(dut3.w_rptr < 2'd3), 32'd1);
      chk("wptr3_max", 32'(dut3.w_wptr < 2'd3), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
